// File: rtl/raizing_pcm_arbiter.sv
// Banked PCM ROM front-end: per-voice bank map, one-entry cache, RR ROM arbiter.
// Optional NMK112 table-area paging is enabled by defining RAIZING_PCM_TABLE_EN.
module raizing_pcm_arbiter #(
  parameter int CH_N    = 2,
  parameter int REQ_AW  = 18,
  parameter int PAGE_AW = 16,
  parameter int BANK_W  = 8,
  parameter int OUT_AW  = 24
) (
  input  logic                     CLK96,
  input  logic                     RESET96_N,
  input  logic [CH_N*REQ_AW-1:0]   CH_ADDR,
  output logic [CH_N*8-1:0]        CH_DATA,
  output logic [CH_N-1:0]          CH_OK,
  input  logic                     BANK_WE,
  input  logic [1:0]               BANK_CH,
  input  logic [REQ_AW-PAGE_AW-1:0] BANK_PG,
  input  logic [BANK_W-1:0]        BANK_D,
  input  logic [CH_N-1:0]          TABLE_MODE,
  output logic                     ROM_CS,
  output logic [OUT_AW-1:0]        ROM_ADDR,
  input  logic [7:0]               ROM_DATA,
  input  logic                     ROM_OK
);

  localparam int PGW = REQ_AW - PAGE_AW;
  localparam int NPG = 1 << PGW;
  localparam int CW  = (CH_N > 1) ? $clog2(CH_N) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, FETCH} state_t;

  state_t state, state_nx;

  logic [BANK_W-1:0]  bank  [CH_N][NPG];
  logic [OUT_AW-1:0]  tag   [CH_N];
  logic [7:0]         data  [CH_N];
  logic [OUT_AW-1:0]  xaddr [CH_N];
  logic [PGW-1:0]     pg    [CH_N];
  logic [PAGE_AW-1:0] off   [CH_N];
  logic [CH_N-1:0]    valid;
  logic [CH_N-1:0]    hit;
  logic [CW-1:0]      gnt;
  logic [CW-1:0]      rr_ptr;
  logic [CW-1:0]      pick;
  logic               found;
  logic               fill;

`ifndef RAIZING_PCM_TABLE_EN
  logic unused_table;
  assign unused_table = ^TABLE_MODE;
`endif

  always_comb begin
    for (int c = 0; c < CH_N; c++) begin
      pg[c]  = CH_ADDR[c*REQ_AW+PAGE_AW +: PGW];
      off[c] = CH_ADDR[c*REQ_AW +: PAGE_AW];
`ifdef RAIZING_PCM_TABLE_EN
      // low 1 KB is the NMK112 sample table, paged in 256-byte slices
      if (TABLE_MODE[c] &&
          CH_ADDR[c*REQ_AW+10 +: REQ_AW-10] == '0) begin
        pg[c]  = PGW'(CH_ADDR[c*REQ_AW+8 +: 2]);
        off[c] = PAGE_AW'(CH_ADDR[c*REQ_AW +: 8]);
      end
`endif
      xaddr[c] = OUT_AW'({bank[c][pg[c]], off[c]});
      hit[c]   = valid[c] && (tag[c] == xaddr[c]);
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    for (int i = 0; i < CH_N; i++) begin
      if (!found && !hit[(int'(rr_ptr) + i) % CH_N]) begin
        found = 1'b1;
        pick  = CW'((int'(rr_ptr) + i) % CH_N);
      end
    end
  end

  always_comb begin
    state_nx = state;
    fill     = 1'b0;
    unique case (state)
      IDLE:   if (found) state_nx = SETTLE;
      SETTLE: state_nx = FETCH;
      FETCH: begin
        if (ROM_OK) begin
          fill     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ROM_CS = (state != IDLE);

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge CLK96) begin
    if (!RESET96_N) begin
      ROM_ADDR <= '0;
      gnt      <= '0;
      rr_ptr   <= '0;
      valid    <= '0;
      CH_OK    <= '0;
      CH_DATA  <= '0;
      for (int c = 0; c < CH_N; c++) begin
        tag[c]  <= '0;
        data[c] <= '0;
        for (int p = 0; p < NPG; p++)
          bank[c][p] <= BANK_W'(p);
      end
    end else begin
      if (state == IDLE && found) begin
        ROM_ADDR <= xaddr[pick];
        gnt      <= pick;
      end
      if (fill) begin
        tag[gnt]   <= ROM_ADDR;
        data[gnt]  <= ROM_DATA;
        valid[gnt] <= 1'b1;
        rr_ptr     <= (int'(gnt) == CH_N-1) ? '0 : gnt + 1'b1;
      end
      if (BANK_WE && int'(BANK_CH) < CH_N)
        bank[BANK_CH[CW-1:0]][BANK_PG] <= BANK_D;
      CH_OK <= hit;
      for (int c = 0; c < CH_N; c++)
        CH_DATA[c*8 +: 8] <= data[c];
    end
  end

endmodule

// File: tb/tb_raizing_pcm_arbiter.sv
// Bench for raizing_pcm_arbiter: directed scenarios plus random steps
// scored against a transaction-level bank/cache/round-robin model.
module tb_raizing_pcm_arbiter;

  localparam int CH_N = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH_N*18-1:0] ch_addr;
  logic [CH_N*8-1:0] ch_data;
  logic [CH_N-1:0]   ch_ok;
  logic              bank_we;
  logic [1:0]        bank_ch;
  logic [1:0]        bank_pg;
  logic [7:0]        bank_d;
  logic [CH_N-1:0]   table_mode;
  logic              rom_cs;
  logic [23:0]       rom_addr;
  logic [7:0]        rom_data;
  logic              rom_ok;

  always #5 clk = ~clk;

  raizing_pcm_arbiter #(.CH_N(CH_N)) dut (
    .CLK96(clk), .RESET96_N(rst_n),
    .CH_ADDR(ch_addr), .CH_DATA(ch_data), .CH_OK(ch_ok),
    .BANK_WE(bank_we), .BANK_CH(bank_ch),
    .BANK_PG(bank_pg), .BANK_D(bank_d),
    .TABLE_MODE(table_mode),
    .ROM_CS(rom_cs), .ROM_ADDR(rom_addr),
    .ROM_DATA(rom_data), .ROM_OK(rom_ok)
  );

  int errors = 0;
  int checks = 0;

  int          mbank [CH_N][4];
  logic [23:0] mtag  [CH_N];
  bit          mvalid[CH_N];
  logic [7:0]  mdat  [CH_N];
  logic [17:0] addr_m[CH_N];
  int          mrr;

  logic [23:0] fetch_q[$];
  int          lat = 3;
  bit          rom_auto = 1'b1;
  bit          fix_en = 1'b0;
  logic [7:0]  fix_val = 8'h00;
  logic [23:0] first_fetch, last_fetch;

  task automatic chk(string t, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_fn(logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic logic [23:0] model_x(int c);
    int pg  = int'(addr_m[c][17:16]);
    int off = int'(addr_m[c][15:0]);
`ifdef RAIZING_PCM_TABLE_EN
    if (table_mode[c] && addr_m[c] < 18'h400) begin
      pg  = int'(addr_m[c][9:8]);
      off = int'(addr_m[c][7:0]);
    end
`endif
    return 24'(mbank[c][pg] * 65536 + off);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH_N; c++) begin
      for (int p = 0; p < 4; p++) mbank[c][p] = p;
      mvalid[c] = 1'b0;
    end
    mrr = 0;
  endtask

  task automatic set_addr(int c, logic [17:0] a);
    ch_addr[c*18 +: 18] = a;
    addr_m[c] = a;
  endtask

  task automatic bank_wr(int c, int p, logic [7:0] d);
    bank_we = 1'b1;
    bank_ch = 2'(c);
    bank_pg = 2'(p);
    bank_d  = d;
    @(negedge clk);
    bank_we = 1'b0;
    if (c < CH_N) mbank[c][p] = d;
  endtask

  // Every channel whose mapped address misses its cached tag is fetched once,
  // in round-robin order from the pointer left by the previous fetch.
  task automatic sync_check(string t);
    logic [23:0] exp_q[$];
    bit          pend[CH_N];
    int          last = -1;
    int          n = 0;
    for (int i = 0; i < CH_N; i++) begin
      int c = (mrr + i) % CH_N;
      logic [23:0] x = model_x(c);
      pend[c] = !(mvalid[c] && mtag[c] == x);
      if (pend[c]) begin
        exp_q.push_back(x);
        last = c;
      end
    end
    if (last >= 0) mrr = (last + 1) % CH_N;
    repeat (2) @(negedge clk);
    while (!(ch_ok == '1 && !rom_cs) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({t, " settle"}, 32'(n < 400), 32'd1);
    chk({t, " nfetch"}, fetch_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < fetch_q.size(); k++)
      chk({t, " order"}, fetch_q[k], exp_q[k]);
    if (fetch_q.size() > 0) begin
      first_fetch = fetch_q[0];
      last_fetch  = fetch_q[fetch_q.size()-1];
    end
    fetch_q.delete();
    for (int c = 0; c < CH_N; c++) begin
      if (pend[c]) begin
        mtag[c]   = model_x(c);
        mvalid[c] = 1'b1;
        mdat[c]   = fix_en ? fix_val : rom_fn(mtag[c]);
      end
      chk({t, " data"}, ch_data[c*8 +: 8], mdat[c]);
    end
  endtask

  function automatic logic [17:0] rnd_addr();
    case ($urandom_range(0, 5))
      0: return 18'h00234;
      1: return 18'h00100;
      2: return 18'h10010;
      3: return 18'h21234;
      4: return 18'h3FFFF;
      default: return 18'($urandom);
    endcase
  endfunction

  initial begin : rom_model
    logic [23:0] ra;
    rom_ok   = 1'b0;
    rom_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rom_auto) begin
        rom_ok = 1'b0;
        if (rom_cs) begin
          ra = rom_addr;
          fetch_q.push_back(ra);
          repeat (lat - 1) @(negedge clk);
          rom_data = fix_en ? fix_val : rom_fn(ra);
          rom_ok   = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    int cyc;
    int bad;
    rst_n = 1'b0;
    ch_addr = '0;
    bank_we = 1'b0;
    bank_ch = '0;
    bank_pg = '0;
    bank_d = '0;
    table_mode = '0;
    for (int c = 0; c < CH_N; c++) begin
      addr_m[c] = '0;
      mtag[c] = '0;
      mdat[c] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst cs", rom_cs, 0);
    chk("rst addr", rom_addr, 0);
    chk("rst ok", ch_ok, 0);
    chk("rst data", ch_data, 0);
    rst_n = 1'b1;
    sync_check("init");

    fix_en = 1'b1;
    fix_val = 8'hA5;
    set_addr(0, 18'h21234);
    cyc = 0;
    for (int i = 1; i <= 20 && cyc == 0; i++) begin
      @(negedge clk);
      if (i == 1) chk("id ok fall", ch_ok[0], 0);
      if (ch_ok[0]) cyc = i;
    end
    chk("id latency", cyc, 5);
    chk("id nfetch", fetch_q.size(), 1);
    if (fetch_q.size() > 0) chk("id rom addr", fetch_q[0], 24'h021234);
    chk("id data", ch_data[7:0], 8'hA5);
    fetch_q.delete();
    mtag[0] = 24'h021234;
    mvalid[0] = 1'b1;
    mdat[0] = 8'hA5;
    mrr = 1;
    fix_en = 1'b0;

    set_addr(0, 18'h21234);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rom_cs || !ch_ok[0]) bad++;
    end
    chk("hit quiet", bad, 0);
    bank_wr(0, 3, 8'h02);
    set_addr(0, 18'h31234);
    sync_check("alias hit");

    bank_wr(1, 3, 8'h17);
    set_addr(1, 18'h30010);
    sync_check("bank17");
    chk("bank17 addr", last_fetch, 24'h170010);
    bank_wr(1, 3, 8'h18);
    sync_check("bank18");
    chk("bank18 addr", last_fetch, 24'h180010);
    bank_wr(2, 0, 8'h77);
    sync_check("oor write");

    set_addr(0, 18'h00050);
    set_addr(1, 18'h10060);
    sync_check("rr0");
    chk("rr0 first", first_fetch, 24'h000050);
    set_addr(0, 18'h00070);
    sync_check("rr single");
    set_addr(0, 18'h00080);
    set_addr(1, 18'h10090);
    sync_check("rr1");
    chk("rr1 first", first_fetch, 24'h010090);
    set_addr(0, 18'h05555);
    set_addr(1, 18'h05555);
    sync_check("same xaddr");

    set_addr(0, 18'h00100);
    repeat (2) @(negedge clk);
    set_addr(0, 18'h00101);
    cyc = 0;
    for (int i = 1; i <= 60 && cyc == 0; i++) begin
      @(negedge clk);
      if (ch_ok[0]) cyc = i;
    end
    chk("mid done", 32'(cyc > 0), 32'd1);
    chk("mid nfetch", fetch_q.size(), 2);
    if (fetch_q.size() == 2) begin
      chk("mid first", fetch_q[0], 24'h000100);
      chk("mid second", fetch_q[1], 24'h000101);
    end
    chk("mid data", ch_data[7:0], rom_fn(24'h000101));
    fetch_q.delete();
    mtag[0] = 24'h000101;
    mdat[0] = rom_fn(24'h000101);
    mrr = 1;

    bank_wr(0, 2, 8'h05);
    sync_check("tbl bank");
    table_mode = 2'b01;
    set_addr(0, 18'h00234);
    sync_check("tbl");
`ifdef RAIZING_PCM_TABLE_EN
    chk("tbl addr", last_fetch, 24'h050034);
`else
    chk("tbl addr", last_fetch, 24'h000234);
`endif

    table_mode = '0;
    sync_check("tbl off");
    rom_auto = 1'b0;
    set_addr(1, 18'h30020);
    repeat (2) @(negedge clk);
    chk("pre rst cs", rom_cs, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid rst cs", rom_cs, 0);
    chk("mid rst ok", ch_ok, 0);
    chk("mid rst data", ch_data, 0);
    chk("mid rst addr", rom_addr, 0);
    rst_n = 1'b1;
    rom_data = 8'hEE;
    rom_ok = 1'b1;
    @(negedge clk);
    rom_ok = 1'b0;
    repeat (2) @(negedge clk);
    chk("late ok", ch_ok, 0);
    model_reset();
    rom_auto = 1'b1;
    sync_check("post rst");

    for (int s = 0; s < 40; s++) begin
      lat = $urandom_range(2, 5);
      if ($urandom_range(0, 1) == 0) begin
        bank_wr($urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom));
      end else begin
        table_mode = CH_N'($urandom);
        for (int c = 0; c < CH_N; c++)
          if ($urandom_range(0, 1) == 1) set_addr(c, rnd_addr());
      end
      sync_check($sformatf("rnd%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
